// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - interrupt controller bus: source lines, mask access, pipeline handshake
interface irq_ctrl_if #(
    parameter int NUM_SRC = 4
);
    localparam int IDW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] irq_src;
    logic               mask_wr;
    logic [NUM_SRC-1:0] mask_wdata;
    logic [NUM_SRC-1:0] irq_mask;
    logic               pipe_ready;
    logic               int_req;
    logic               int_ack;
    logic [31:0]        handler_addr;
    logic [IDW-1:0]     int_id;
    logic               mret;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic               spurious_ret;

    modport slave (
        input  irq_src, mask_wr, mask_wdata, pipe_ready, int_ack, mret,
        output irq_mask, int_req, handler_addr, int_id, in_service, pending, spurious_ret
    );

    modport master (
        output irq_src, mask_wr, mask_wdata, pipe_ready, int_ack, mret,
        input  irq_mask, int_req, handler_addr, int_id, in_service, pending, spurious_ret
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-latched, maskable, round-robin interrupt arbiter
module irq_ctrl #(
    parameter int                  NUM_SRC    = 4,
    parameter logic [31:0]         VEC_BASE   = 32'h0000_0100,
    parameter int                  VEC_STRIDE = 16,
    parameter logic [NUM_SRC-1:0]  MASK_RST   = '1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    irq_ctrl_if.slave   bus
);
    localparam int IDW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_int_id;
    logic [31:0]        r_handler_addr;
    logic               r_spurious;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_found;
    logic [IDW-1:0]     w_pick;
    logic               w_grant;
    logic               w_take_ack;

    assign w_edge     = r_s2 & ~r_prev;
    assign w_eligible = r_pending & r_mask;

    // First eligible source at or after rr_ptr, wrapping around.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_SRC;
            if (!w_found && w_eligible[v_idx]) begin
                w_found = 1'b1;
                w_pick  = IDW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_take_ack   = 1'b0;
        w_clr        = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && bus.pipe_ready) begin
                    w_grant      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.int_ack) begin
                    w_take_ack      = 1'b1;
                    w_clr[r_int_id] = 1'b1;
                    w_state_next    = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (bus.mret) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1           <= '0;
            r_s2           <= '0;
            r_prev         <= '0;
            r_pending      <= '0;
            r_mask         <= MASK_RST;
            r_rr_ptr       <= '0;
            r_int_id       <= '0;
            r_handler_addr <= VEC_BASE;
            r_spurious     <= 1'b0;
        end else begin
            r_s1   <= bus.irq_src;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            // A fresh edge on the acked source wins over its clear.
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (bus.mask_wr) begin
                r_mask <= bus.mask_wdata;
            end
            if (w_grant) begin
                r_int_id       <= w_pick;
                r_handler_addr <= VEC_BASE + 32'(w_pick) * 32'(VEC_STRIDE);
            end
            if (w_take_ack) begin
                r_rr_ptr <= (r_int_id == IDW'(NUM_SRC - 1)) ? '0 : r_int_id + IDW'(1);
            end
            r_spurious <= bus.mret && (r_state != S_SERVICE);
        end
    end

    assign bus.irq_mask     = r_mask;
    assign bus.int_req      = (r_state == S_REQ);
    assign bus.in_service   = (r_state == S_SERVICE);
    assign bus.handler_addr = r_handler_addr;
    assign bus.int_id       = r_int_id;
    assign bus.pending      = r_pending;
    assign bus.spurious_ret = r_spurious;
endmodule
